// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation modes, comparison
// verdicts and controller states, plus a helper to flip a comparison verdict.
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_CMP = 2'b10,
        MODE_AND = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Swap LT and GT; EQ passes through untouched.
    function automatic cmp_e cmp_swap(input cmp_e c);
        case (c)
            CMP_LT:  return CMP_GT;
            CMP_GT:  return CMP_LT;
            default: return c;
        endcase
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice reused every cycle by alu_serial. Produces the function
// bit, the carry for the next bit and the updated comparison verdict.
module alu_slice
    import alu_pkg::*;
(
    input  logic  a_i,
    input  logic  b_i,
    input  logic  cin_i,
    input  mode_e mode_i,
    input  cmp_e  cmp_i,
    output logic  f_o,
    output logic  cout_o,
    output cmp_e  cmp_o
);

    logic b_eff;

    // Full adder for ADD/SUB, bitwise AND, and an LSB-first magnitude compare
    // where a differing bit overrides whatever the lower bits decided.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        f_o    = 1'b0;
        cout_o = cin_i;
        cmp_o  = cmp_i;
        b_eff  = b_i ^ (mode_i == MODE_SUB);
        case (mode_i)
            MODE_ADD, MODE_SUB: begin
                f_o    = a_i ^ b_eff ^ cin_i;
                cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
            end
            MODE_CMP: begin
                if (a_i != b_i) begin
                    cmp_o = a_i ? CMP_GT : CMP_LT;
                end
            end
            MODE_AND: begin
                f_o = a_i & b_i;
            end
            default: begin
                f_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU between the operand register file and result writeback.
// Operands are captured on an accepted start and pushed LSB first through a
// single alu_slice; results and flags are registered once all bits are done.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit CMP_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [1:0]       cmp,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);
    // One extra RUN cycle after the MSB is spent registering the results.
    localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

    // Controller and datapath state
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    mode_e            mode_q;
    logic             carry_q;
    logic             carry_msb_q;
    cmp_e             cmp_acc_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    cmp_e             cmp_q;
    logic             ovf_q;
    logic             zero_q;

    // Combinational next values
    mode_e            mode_in;
    logic             accept;
    logic             f_d;
    logic             carry_d;
    cmp_e             slice_cmp;
    cmp_e             cmp_acc_d;
    logic             arith;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic             ovf_d;
    cmp_e             cmp_d;
    logic             zero_d;

    assign mode_in = mode_e'(mode);
    assign accept  = start && (state_q != ST_RUN);

    alu_slice u_slice (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .mode_i (mode_q),
        .cmp_i  (cmp_acc_q),
        .f_o    (f_d),
        .cout_o (carry_d),
        .cmp_o  (slice_cmp)
    );

    // Comparison verdict after this bit; a sign-bit difference reverses it for signed compares.
    always_comb begin
        cmp_acc_d = slice_cmp;
        if (CMP_SIGNED && (cnt_q == CNT_MSB) && (a_q[0] != b_q[0])) begin
            cmp_acc_d = cmp_swap(slice_cmp);
        end
    end

    // Mode-dependent result and flags, valid once every bit has been processed.
    always_comb begin
        arith    = (mode_q == MODE_ADD) || (mode_q == MODE_SUB);
        result_d = (mode_q == MODE_CMP) ? '0 : acc_q;
        cout_d   = arith ? carry_q : 1'b0;
        ovf_d    = arith ? (carry_msb_q ^ carry_q) : 1'b0;
        cmp_d    = (mode_q == MODE_CMP) ? cmp_acc_q : CMP_EQ;
        zero_d   = (result_d == '0);
    end

    // Controller, operand shift registers and result registers in one clocked process.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mode_q      <= MODE_ADD;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            cmp_acc_q   <= CMP_EQ;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            cmp_q       <= CMP_EQ;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == CNT_END) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                        cout_q   <= cout_d;
                        cmp_q    <= cmp_d;
                        ovf_q    <= ovf_d;
                        zero_q   <= zero_d;
                    end else begin
                        a_q       <= a_q >> 1;
                        b_q       <= b_q >> 1;
                        acc_q     <= {f_d, acc_q[WIDTH-1:1]};
                        carry_q   <= carry_d;
                        cmp_acc_q <= cmp_acc_d;
                        if (cnt_q == CNT_MSB) begin
                            carry_msb_q <= carry_q;
                        end
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        a_q         <= a;
                        b_q         <= b;
                        acc_q       <= '0;
                        mode_q      <= mode_in;
                        carry_q     <= ((mode_in == MODE_ADD) || (mode_in == MODE_SUB)) ? cin : 1'b0;
                        carry_msb_q <= 1'b0;
                        cmp_acc_q   <= CMP_EQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign cmp    = cmp_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial. Three instances run side by side:
// dut 0 WIDTH=4 unsigned compare, dut 1 WIDTH=4 signed compare, dut 2 WIDTH=8.
// Expected values come from an arithmetic reference model in this file.
module tb_alu_serial;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_CMP = 2'b10;
    localparam logic [1:0] M_AND = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [1:0] mode;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       cin;

    logic [2:0] busy_v, done_v, cout_v, ovf_v, zero_v;
    logic [3:0] res_u, res_s;
    logic [7:0] res_w;
    logic [1:0] cmp_u, cmp_s, cmp_w;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_res [3];

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(4), .CMP_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .a(a4), .b(b4), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_u), .cout(cout_v[0]),
        .cmp(cmp_u), .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    alu_serial #(.WIDTH(4), .CMP_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .a(a4), .b(b4), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_s), .cout(cout_v[1]),
        .cmp(cmp_s), .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    alu_serial #(.WIDTH(8), .CMP_SIGNED(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .a(a8), .b(b8), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_w), .cout(cout_v[2]),
        .cmp(cmp_w), .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    function automatic int w_of(input int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic bit sg_of(input int d);
        return (d == 1);
    endfunction

    function automatic logic [7:0] res_of(input int d);
        case (d)
            0:       return {4'b0, res_u};
            1:       return {4'b0, res_s};
            default: return res_w;
        endcase
    endfunction

    function automatic logic [1:0] cmp_of(input int d);
        case (d)
            0:       return cmp_u;
            1:       return cmp_s;
            default: return cmp_w;
        endcase
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int w, input bit sgn, input logic [1:0] m, input int x, input int y,
                         input logic c, output int r, output logic co, output logic [1:0] cm,
                         output logic ov, output logic z);
        int mask, half, sx, sy, s, ss;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sx   = (x >= half) ? x - (1 << w) : x;
        sy   = (y >= half) ? y - (1 << w) : y;
        r = 0; co = 1'b0; cm = 2'b00; ov = 1'b0;
        case (m)
            M_ADD: begin
                s  = x + y + int'(c);
                r  = s & mask;
                co = ((s >> w) & 1) != 0;
                ss = sx + sy + int'(c);
                ov = (ss > half - 1) || (ss < -half);
            end
            M_SUB: begin
                s  = x + ((~y) & mask) + int'(c);
                r  = s & mask;
                co = ((s >> w) & 1) != 0;
                ss = sx - sy - 1 + int'(c);
                ov = (ss > half - 1) || (ss < -half);
            end
            M_CMP: begin
                if (sgn) cm = (sx == sy) ? 2'b00 : (sx < sy) ? 2'b01 : 2'b10;
                else     cm = (x == y)   ? 2'b00 : (x < y)   ? 2'b01 : 2'b10;
            end
            default: r = x & y;
        endcase
        z = (r == 0);
    endtask

    task automatic scramble();
        mode = 2'($urandom);
        a4   = 4'($urandom);
        b4   = 4'($urandom);
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin  = 1'($urandom);
    endtask

    // One operation on all three instances; optionally pulses start on RUN cycle 2.
    task automatic run_op(input string name, input logic [1:0] m, input logic [3:0] x4,
                          input logic [3:0] y4, input logic [7:0] x8, input logic [7:0] y8,
                          input logic c, input bit mid_pulse);
        int er [3];
        logic eco [3];
        logic [1:0] ecm [3];
        logic eov [3];
        logic ez [3];
        logic ed, eb;
        for (int d = 0; d < 3; d++) begin
            model(w_of(d), sg_of(d), m, (d < 2) ? int'(x4) : int'(x8),
                  (d < 2) ? int'(y4) : int'(y8), c, er[d], eco[d], ecm[d], eov[d], ez[d]);
        end
        mode = m; a4 = x4; b4 = y4; a8 = x8; b8 = y8; cin = c;
        start_v = 3'b111;
        @(posedge clk); #1;
        start_v = 3'b000;
        scramble();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b1 || done_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s accept dut%0d: busy=%b done=%b, want busy=1 done=0", name, d, busy_v[d], done_v[d]);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                ed = (k == w_of(d) + 1);
                eb = (k <= w_of(d));
                checks++;
                if (done_v[d] !== ed) begin
                    errors++;
                    $display("FAIL %s done dut%0d edge %0d: got %b want %b", name, d, k, done_v[d], ed);
                end
                checks++;
                if (busy_v[d] !== eb) begin
                    errors++;
                    $display("FAIL %s busy dut%0d edge %0d: got %b want %b", name, d, k, busy_v[d], eb);
                end
                if (k == 1) begin
                    checks++;
                    if (res_of(d) !== prev_res[d]) begin
                        errors++;
                        $display("FAIL %s hold dut%0d: result %h want previous %h", name, d, res_of(d), prev_res[d]);
                    end
                end
                if (ed) begin
                    checks++;
                    if (res_of(d) !== 8'(er[d]) || cout_v[d] !== eco[d] || cmp_of(d) !== ecm[d] ||
                        ovf_v[d] !== eov[d] || zero_v[d] !== ez[d]) begin
                        errors++;
                        $display("FAIL %s outputs dut%0d: got res=%h cout=%b cmp=%b ovf=%b zero=%b want res=%h cout=%b cmp=%b ovf=%b zero=%b",
                                 name, d, res_of(d), cout_v[d], cmp_of(d), ovf_v[d], zero_v[d],
                                 8'(er[d]), eco[d], ecm[d], eov[d], ez[d]);
                    end
                    prev_res[d] = 8'(er[d]);
                end
            end
            if (mid_pulse && k == 2) begin
                start_v = 3'b111;
                scramble();
            end else begin
                start_v = 3'b000;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || res_of(d) !== 8'h00 || cout_v[d] !== 1'b0 ||
                cmp_of(d) !== 2'b00 || ovf_v[d] !== 1'b0 || zero_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b res=%h cout=%b cmp=%b ovf=%b zero=%b, want 0 0 00 0 00 0 1",
                         d, busy_v[d], done_v[d], res_of(d), cout_v[d], cmp_of(d), ovf_v[d], zero_v[d]);
            end
            prev_res[d] = 8'h00;
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        run_op("add_7_5", M_ADD, 4'b0111, 4'b0101, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op("add_cin", M_ADD, 4'b1111, 4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_3_5", M_SUB, 4'b0011, 4'b0101, 8'h03, 8'h05, 1'b1, 1'b0);
        run_op("sub_eq",  M_SUB, 4'b0101, 4'b0101, 8'h80, 8'h01, 1'b1, 1'b0);
    endtask

    task automatic test_compare();
        run_op("cmp_8_7", M_CMP, 4'b1000, 4'b0111, 8'h80, 8'h7F, 1'b1, 1'b0);
        run_op("cmp_eq",  M_CMP, 4'b1010, 4'b1010, 8'hA5, 8'hA5, 1'b1, 1'b0);
    endtask

    task automatic test_and();
        run_op("and", M_AND, 4'b1100, 4'b1010, 8'hF0, 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_mid_start();
        run_op("mid_start", M_ADD, 4'b0110, 4'b0011, 8'h5A, 8'h33, 1'b0, 1'b1);
    endtask

    // Second start held through the DONE cycle of the first on dut 0 only.
    task automatic test_back_to_back();
        logic [1:0] m [2];
        logic [3:0] x [2], y [2];
        logic c [2];
        int er [2];
        logic eco [2];
        logic [1:0] ecm [2];
        logic eov [2], ez [2];
        m[0] = M_ADD; m[1] = M_SUB;
        for (int op = 0; op < 2; op++) begin
            x[op] = 4'($urandom);
            y[op] = 4'($urandom);
            c[op] = 1'($urandom);
            model(4, 1'b0, m[op], int'(x[op]), int'(y[op]), c[op], er[op], eco[op], ecm[op], eov[op], ez[op]);
        end
        mode = m[0]; a4 = x[0]; b4 = y[0]; cin = c[0];
        start_v = 3'b001;
        @(posedge clk); #1;
        for (int op = 0; op < 2; op++) begin
            start_v = 3'b000;
            checks++;
            if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b accept op%0d: busy=%b done=%b want 1/0", op, busy_v[0], done_v[0]);
            end
            scramble();
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk); #1;
                checks++;
                if (done_v[0] !== (k == 5)) begin
                    errors++;
                    $display("FAIL b2b done op%0d edge %0d: got %b want %b", op, k, done_v[0], (k == 5));
                end
                if (k == 5) begin
                    checks++;
                    if (res_u !== 4'(er[op]) || cout_v[0] !== eco[op] || ovf_v[0] !== eov[op] || zero_v[0] !== ez[op]) begin
                        errors++;
                        $display("FAIL b2b outputs op%0d: got res=%h cout=%b ovf=%b zero=%b want res=%h cout=%b ovf=%b zero=%b",
                                 op, res_u, cout_v[0], ovf_v[0], zero_v[0], 4'(er[op]), eco[op], eov[op], ez[op]);
                    end
                    prev_res[0] = 8'(er[op]);
                    if (op == 0) begin
                        mode = m[1]; a4 = x[1]; b4 = y[1]; cin = c[1];
                        start_v = 3'b001;
                    end
                end
            end
            if (op == 0) begin
                @(posedge clk); #1;
            end
        end
        start_v = 3'b000;
    endtask

    task automatic test_reset_mid_run();
        mode = M_ADD; a4 = 4'b0111; b4 = 4'b0101; a8 = 8'h77; b8 = 8'h55; cin = 1'b1;
        start_v = 3'b111;
        @(posedge clk); #1;
        start_v = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || res_of(d) !== 8'h00 ||
                cmp_of(d) !== 2'b00 || zero_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset dut%0d: busy=%b done=%b res=%h cmp=%b zero=%b, want 0 0 00 00 1",
                         d, busy_v[d], done_v[d], res_of(d), cmp_of(d), zero_v[d]);
            end
            prev_res[d] = 8'h00;
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done_v !== 3'b000) begin
                errors++;
                $display("FAIL mid_reset stray done edge %0d: got %b want 000", k, done_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op("random", 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                   8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; start_v = 3'b000; mode = 2'b00;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0; cin = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_and();
        test_ignore_mid_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
